sram_port_arbiter: RTL
======================

Name: sram_port_arbiter

Overview:
- Shares the single-port boot SRAM between two picorv32-native-protocol masters: port 0 (CPU) and port 1 (accelerator/DMA engine).
- Sits between the masters and the SRAM instance, which has a synchronous 1-cycle read and byte write enables.
- Arbitration is round-robin, and a granted transfer is held until its one-cycle ready pulse.
- Also performs RAM range check, unmapped-access response and contention statistics.

Parameters:
- MEM_WORDS, 4096, SRAM depth in 32-bit words; RAM region is byte address < 4*MEM_WORDS.
- CNT_W, 16, width of the saturating contention counter.

Ports:
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- m0_valid  in  1  CPU request; held high until m0_ready
- m0_addr  in  32  CPU byte address
- m0_wdata  in  32  CPU write data
- m0_wstrb  in  4  CPU byte strobes; 0 = read
- m0_ready  out  1  one-cycle transfer-complete pulse to CPU
- m0_rdata  out  32  CPU read data, valid when m0_ready
- m1_valid, m1_addr, m1_wdata, m1_wstrb, m1_ready, m1_rdata: same as m0_*, for the accelerator
- s_addr  out  22  SRAM word address
- s_wdata  out  32  SRAM write data
- s_wen  out  4  SRAM byte write enables
- s_rdata  in  32  SRAM read data, valid the cycle after the address
- err_unmapped  out  1  one-cycle pulse on an out-of-range access
- contention_cnt  out  CNT_W  saturating count of cycles where both masters request in IDLE

Behaviour:
- Reset values: state=IDLE, gnt=0, last=1, m0_ready=m1_ready=0, m*_rdata=0, s_wen=0, s_addr=0, s_wdata=0, err_unmapped=0, contention_cnt=0.
- s_wen is forced 0 whenever resetn=0, regardless of state.
- FSM states: IDLE -> ACCESS -> RESP -> IDLE. All state and grant are registered.
- IDLE, no request: stay in IDLE.
- IDLE, exactly one valid: grant that master, go to ACCESS.
- IDLE, both valid: grant !last, go to ACCESS. last=1 after reset, so the CPU wins the first tie.
- IDLE, both valid (contention): contention_cnt increments, saturating at all-ones.
- On a grant: latch gnt; set last=gnt; latch addr/wdata/wstrb of the granted master; latch hit = (addr < 4*MEM_WORDS).
- ACCESS: s_addr=latched addr[23:2]; s_wdata=latched wdata; s_wen = hit ? latched wstrb : 0. Go to RESP.
- RESP: m{gnt}_ready=1 for exactly this cycle; other master's ready=0.
- RESP read data: m{gnt}_rdata = hit ? s_rdata : 0. Write responses carry don't-care rdata (0 preferred).
- RESP, unmapped (!hit): err_unmapped=1 for this cycle. Access still completes, so the master never hangs.
- RESP: go to IDLE.
- Non-granted master: ready=0, rdata=0 throughout.
- Latency: request seen in IDLE at cycle T -> ready at T+2.
- Throughput: one transfer per 3 cycles. Back-to-back requests from the same master re-enter arbitration in IDLE.
- Outside ACCESS: s_addr and s_wdata hold their last values, s_wen=0.
- Outside RESP: both readys are 0.
- Fairness: under continuous contention grants strictly alternate 0,1,0,1. A master waits at most one foreign transfer (3 cycles) before its grant.
- Only latched request fields are used; master signals changing after the grant are ignored.
- Boundaries: addr 4*MEM_WORDS-4 is in range; 4*MEM_WORDS is unmapped. Misaligned addr[1:0] are ignored; word address only.
- Reset mid-transfer (ACCESS or RESP): abandon the transfer; no ready pulse; no SRAM write on that edge; FSM returns to IDLE.

Test Plan:
- Single CPU read, mem[5]=0xDEADBEEF, m0 reads addr 0x14 at T -> s_addr=5 at T+1; m0_ready=1 and m0_rdata=0xDEADBEEF at T+2 only; m1_ready stays 0.
- Byte write, m1 writes addr 0x20, wdata 0x11223344, wstrb 4'b0100 -> s_wen=4'b0100 for one cycle; a later read of word 8 returns prior data with byte 2 = 0x22.
- Tie after reset: both masters request reads continuously for 12 cycles -> grant order 0,1,0,1; each sees ready every 6 cycles; contention_cnt=4 (ties at 0,3,6,9).
- Unmapped access: m0 write to 0x0000_4000 (MEM_WORDS=4096) -> s_wen stays 0, m0_ready and err_unmapped pulse at T+2; read to 0x4000 returns 0. Access to 0x3FFC is in range, no error.
- Reset mid-write: resetn low during ACCESS of an m1 write -> s_wen=0 that cycle; SRAM word unchanged; no ready pulse; outputs at reset values next cycle.
- Saturation: with CNT_W=4, hold both masters requesting through 20 ties -> contention_cnt sticks at 15.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//   Shares one single-port boot SRAM between two masters that speak the
//   picorv32 native memory protocol: port 0 (CPU) and port 1 (accelerator /
//   DMA engine). Arbitration is round-robin. A granted transfer runs
//   IDLE -> ACCESS -> RESP, so each transfer takes three cycles. Requests
//   outside the RAM region still complete, return zero read data and raise
//   err_unmapped. The block also counts the IDLE cycles in which both
//   masters request at once (contention_cnt, saturating).
//
// Handshake (both master ports):
//   The master raises mN_valid with addr/wdata/wstrb stable and holds valid
//   until mN_ready. mN_ready is a single-cycle pulse that completes the
//   transfer; mN_rdata is meaningful only while mN_ready is high (reads only).
//   The request fields are captured at the grant, so changes the master makes
//   after that point do not affect the transfer in flight.
//
// Ports:
//   clk, resetn                 clock; synchronous active-low reset
//   m0_valid/addr/wdata/wstrb   CPU request (wstrb == 0 means read)
//   m0_ready, m0_rdata          CPU completion pulse and read data
//   m1_*                        same as m0_*, for the accelerator
//   s_addr, s_wdata, s_wen      SRAM word address, write data, byte enables
//   s_rdata                     SRAM read data, valid the cycle after s_addr
//   err_unmapped                one-cycle pulse on an out-of-range access
//   contention_cnt              saturating count of IDLE cycles with a tie
//   dbg_state                   current FSM state (0 IDLE, 1 ACCESS, 2 RESP)

module sram_port_arbiter #(
  parameter int MEM_WORDS = 4096,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             resetn,

  input  logic             m0_valid,
  input  logic [31:0]      m0_addr,
  input  logic [31:0]      m0_wdata,
  input  logic [3:0]       m0_wstrb,
  output logic             m0_ready,
  output logic [31:0]      m0_rdata,

  input  logic             m1_valid,
  input  logic [31:0]      m1_addr,
  input  logic [31:0]      m1_wdata,
  input  logic [3:0]       m1_wstrb,
  output logic             m1_ready,
  output logic [31:0]      m1_rdata,

  output logic [21:0]      s_addr,
  output logic [31:0]      s_wdata,
  output logic [3:0]       s_wen,
  input  logic [31:0]      s_rdata,

  output logic             err_unmapped,
  output logic [CNT_W-1:0] contention_cnt,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Byte size of the RAM region. One bit wider than an address so the
  // compare stays correct for any MEM_WORDS up to 2^30.
  localparam logic [32:0]      RAM_BYTES = 33'(MEM_WORDS) * 33'd4;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  // ---------------------------------------------------------------------
  // Registered state
  // ---------------------------------------------------------------------
  state_t           state;
  logic             gnt;        // master owning the current transfer
  logic             last;       // master granted most recently
  logic             hit_q;      // latched request lies inside the RAM region
  logic [3:0]       wstrb_q;    // latched strobes; 0 marks a read
  logic [21:0]      s_addr_q;
  logic [31:0]      s_wdata_q;
  logic [3:0]       s_wen_q;
  logic             ready0_q;
  logic             ready1_q;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q;

  // ---------------------------------------------------------------------
  // Request selection in IDLE
  // ---------------------------------------------------------------------
  logic        any_valid;
  logic        both_valid;
  logic        sel;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [3:0]  sel_wstrb;
  logic        sel_hit;

  always_comb begin
    any_valid  = m0_valid | m1_valid;
    both_valid = m0_valid & m1_valid;
    // On a tie the master that did not win last time is served. With a
    // single requester that requester is served. last resets to 1 so the
    // CPU wins the first tie after reset.
    sel        = both_valid ? ~last : m1_valid;
    sel_addr   = sel ? m1_addr  : m0_addr;
    sel_wdata  = sel ? m1_wdata : m0_wdata;
    sel_wstrb  = sel ? m1_wstrb : m0_wstrb;
    sel_hit    = ({1'b0, sel_addr} < RAM_BYTES);
  end

  // ---------------------------------------------------------------------
  // FSM and datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      gnt       <= 1'b0;
      last      <= 1'b1;
      hit_q     <= 1'b0;
      wstrb_q   <= 4'b0;
      s_addr_q  <= 22'b0;
      s_wdata_q <= 32'b0;
      s_wen_q   <= 4'b0;
      ready0_q  <= 1'b0;
      ready1_q  <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      // Pulse-type outputs default low; only the transitions below raise them.
      s_wen_q  <= 4'b0;
      ready0_q <= 1'b0;
      ready1_q <= 1'b0;
      err_q    <= 1'b0;

      case (state)
        IDLE: begin
          if (both_valid && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + CNT_ONE;
          end
          if (any_valid) begin
            gnt       <= sel;
            last      <= sel;
            hit_q     <= sel_hit;
            wstrb_q   <= sel_wstrb;
            // The SRAM-side registers are loaded straight from the selected
            // request so they present the latched transfer during ACCESS and
            // then hold until the next grant.
            s_addr_q  <= sel_addr[23:2];
            s_wdata_q <= sel_wdata;
            s_wen_q   <= sel_hit ? sel_wstrb : 4'b0;
            state     <= ACCESS;
          end
        end

        ACCESS: begin
          // The SRAM samples address/enables at the end of this cycle; its
          // read data is on s_rdata during RESP.
          ready0_q <= ~gnt;
          ready1_q <= gnt;
          err_q    <= ~hit_q;
          state    <= RESP;
        end

        RESP: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  // Read data is taken combinationally from the SRAM during RESP because the
  // SRAM only produces it in that cycle. Unmapped accesses and writes return
  // zero. Everything that could start or complete a transfer is gated by
  // resetn, so asserting reset during ACCESS or RESP suppresses both the
  // SRAM write on that edge and the ready pulse.
  logic rd_ok;

  always_comb begin
    rd_ok          = hit_q && (wstrb_q == 4'b0);
    m0_ready       = resetn & ready0_q;
    m1_ready       = resetn & ready1_q;
    m0_rdata       = (m0_ready && rd_ok) ? s_rdata : 32'b0;
    m1_rdata       = (m1_ready && rd_ok) ? s_rdata : 32'b0;
    s_addr         = s_addr_q;
    s_wdata        = s_wdata_q;
    s_wen          = resetn ? s_wen_q : 4'b0;
    err_unmapped   = resetn & err_q;
    contention_cnt = cnt_q;
    dbg_state      = state;
  end

endmodule
